rx_frame_buf: RTL and testbench
===============================

# rx_frame_buf

Receive-side frame buffer for the raw 10G link. It pairs with the TX-side word RAM. It accepts 64-bit words from the RX lane decoder, which cannot be back-pressured, and holds them in a single-clock FIFO. It presents them to the user side with a valid/ready handshake. On overflow or a framing error it truncates the damaged frame by inserting an error terminator word, so downstream logic always sees well-formed sop…eop sequences.

## Interface
- ADDR_WIDTH, 4, log2 of FIFO depth (range 4..10); depth = 2^ADDR_WIDTH words of 70 bits.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input word present (no back-pressure).
- s_data  in  64  input payload.
- s_nbytes  in  3  valid bytes in the word; 0 means 8; meaningful only with s_eop.
- s_sop  in  1  first word of frame.
- s_eop  in  1  last word of frame.
- s_err  in  1  decoder error flag, stored and forwarded unchanged.
- m_valid  out  1  output word available.
- m_ready  in  1  consumer accepts word when m_valid & m_ready.
- m_data  out  64  output payload.
- m_nbytes  out  3  output byte count.
- m_sop, m_eop, m_err  out  1 each  output framing flags.
- level  out  ADDR_WIDTH+1  stored word count, 0..2^ADDR_WIDTH.
- drop_cnt  out  16  saturating count of drop events.

## Operation
- Storage word is {err, eop, sop, nbytes[2:0], data[63:0]} = 70 bits. It is a behavioural array with wr_ptr/rd_ptr wrapping modulo depth.
- `full` = (level == depth), taken from the registered level. A write is never accepted when full, even if a read occurs in the same cycle. There is no bypass from input to output.
- Write-side FSM:
  - **IDLE**
    - s_valid & s_sop, not full: store the word. Go to FRAME, or stay in IDLE if s_eop is also set.
    - s_valid & !s_sop: word dropped; drop_cnt +1.
    - s_valid & s_sop while full: word dropped; drop_cnt +1. Go to DROP with term_pend=0, or stay in IDLE if s_eop is also set.
  - **FRAME**
    - s_valid & !s_sop, not full: store the word. Go to IDLE on s_eop.
    - s_valid while full: word dropped; term_pend=1; drop_cnt +1. Go to DROP, or go to TERM if the word had s_eop.
    - s_valid & s_sop (missing eop): word dropped; term_pend=1; drop_cnt +1. Go to DROP, or go to TERM if s_eop is also set.
  - **DROP**
    - All input words are discarded.
    - If term_pend and not full: write the terminator and clear term_pend.
    - On s_valid & s_eop: go to IDLE if term_pend is clear after this cycle, else go to TERM.
  - **TERM**
    - All input words are discarded, each adding drop_cnt +1.
    - When not full: write the terminator, clear term_pend, go to IDLE.
- The terminator word is data=0, nbytes=0, sop=0, eop=1, err=1.
- Read side:
  - m_valid = (level != 0).
  - m_* come combinationally from array[rd_ptr] and are forced to 0 when m_valid=0.
  - rd_ptr advances on m_valid & m_ready.
- level update: +1 on a write only, −1 on a read only, unchanged when both or neither occur.
- drop_cnt saturates at 16'hFFFF.

## Timing
- Reset values: m_valid=0, all m_* outputs 0, level=0, drop_cnt=0, state IDLE, term_pend=0, pointers 0. Array contents are not reset.
- Latency: a word written in cycle N is visible on m_* in cycle N+1.
- Full throughput: one write and one read per cycle.
- Reset asserted mid-frame discards all stored words and any pending terminator. The next accepted word must carry sop.
- Pointer wrap from 2^ADDR_WIDTH−1 to 0 is seamless.
- m_ready while m_valid=0 has no effect.

## Configuration
- RX_FRAME_BUF_STATS_EN defined: the drop_cnt counter is implemented as above.
- Not defined: drop_cnt is constant 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- **Single frame:** reset, then sop word D0 followed by 3 words with eop on the 4th (nbytes=5), m_ready=1. m_valid rises 1 cycle after D0; 4 words come out in order with sop/eop/nbytes=5 intact; level ends at 0; drop_cnt=0.
- **Overflow truncation:** m_ready=0, 20-word frame, ADDR_WIDTH=4. Words 0..15 are stored; word 16 is dropped; level=16; drop_cnt=1. After releasing m_ready, 16 words drain, then the terminator (eop=1, err=1, data=0). Nothing from words 17..19 appears.
- **Missing eop:** frame A with sop followed by 2 words, then a new sop with no eop on A. A's 3 words are output followed by a terminator. The second frame is dropped through its eop; drop_cnt=1.
- **Stray words:** 3 non-sop words in IDLE. Nothing is stored; drop_cnt=3.
- **Full with simultaneous read/write:** FIFO full, m_ready=1, valid sop word. The write is rejected and level goes 16→15. The frame is counted as dropped (drop_cnt +1) and its remaining words are discarded until eop.
- **Reset mid-frame plus macro off:** rst pulsed with 5 words stored. Next cycle m_valid=0, level=0. Build without RX_FRAME_BUF_STATS_EN and repeat the overflow test: drop_cnt stays 0 and the data path is identical.

Source files
------------

// File: rtl/rx_frame_buf.sv
// Receive-side frame buffer: single-clock FIFO that never back-pressures the lane decoder and
// truncates damaged frames with an error terminator. Define RX_FRAME_BUF_STATS_EN to build drop_cnt.
module rx_frame_buf #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [63:0]           s_data,
    input  logic [2:0]            s_nbytes,
    input  logic                  s_sop,
    input  logic                  s_eop,
    input  logic                  s_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [63:0]           m_data,
    output logic [2:0]            m_nbytes,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  m_err,
    output logic [ADDR_WIDTH:0]   level,
    output logic [15:0]           drop_cnt
);

    localparam int DATA_W = 64;
    localparam int WORD_W = DATA_W + 6;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LVL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WORD_W-1:0]     TERM_WORD = {1'b1, 1'b1, 1'b0, 3'b000, {DATA_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_DROP,
        S_TERM
    } state_t;

    state_t                 state, state_nxt;
    logic                   term_pend, term_pend_nxt;
    logic [WORD_W-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]    level_r;
    logic                   full;
    logic                   wr_en;
    logic                   wr_term;
    logic                   rd_en;
    logic                   drop_evt;
    logic [WORD_W-1:0]      wr_word;
    logic [WORD_W-1:0]      rd_word;

    assign full = (level_r == LVL_FULL);

    always_comb begin
        state_nxt     = state;
        term_pend_nxt = term_pend;
        wr_en         = 1'b0;
        wr_term       = 1'b0;
        drop_evt      = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_valid) begin
                    if (!s_sop) begin
                        drop_evt = 1'b1;
                    end else if (full) begin
                        drop_evt = 1'b1;
                        if (!s_eop) begin
                            state_nxt     = S_DROP;
                            term_pend_nxt = 1'b0;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (!s_eop) state_nxt = S_FRAME;
                    end
                end
            end
            S_FRAME: begin
                if (s_valid) begin
                    // Frame already partly stored: any loss must be closed with a terminator
                    if (full || s_sop) begin
                        drop_evt      = 1'b1;
                        term_pend_nxt = 1'b1;
                        state_nxt     = s_eop ? S_TERM : S_DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (s_eop) state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (term_pend && !full) begin
                    wr_en         = 1'b1;
                    wr_term       = 1'b1;
                    term_pend_nxt = 1'b0;
                end
                if (s_valid && s_eop) state_nxt = term_pend_nxt ? S_TERM : S_IDLE;
            end
            S_TERM: begin
                if (s_valid) drop_evt = 1'b1;
                if (!full) begin
                    wr_en         = 1'b1;
                    wr_term       = 1'b1;
                    term_pend_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                term_pend_nxt = 1'b0;
            end
        endcase
    end

    assign wr_word = wr_term ? TERM_WORD : {s_err, s_eop, s_sop, s_nbytes, s_data};
    assign rd_en   = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            term_pend <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_r   <= '0;
        end else begin
            state     <= state_nxt;
            term_pend <= term_pend_nxt;
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, rd_en})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array carries no reset; only the pointers and level define its contents
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr] <= wr_word;
    end

    assign rd_word  = mem[rd_ptr];
    assign m_valid  = (level_r != '0);
    assign m_data   = m_valid ? rd_word[DATA_W-1:0]        : '0;
    assign m_nbytes = m_valid ? rd_word[DATA_W+2:DATA_W]   : '0;
    assign m_sop    = m_valid ? rd_word[DATA_W+3]          : 1'b0;
    assign m_eop    = m_valid ? rd_word[DATA_W+4]          : 1'b0;
    assign m_err    = m_valid ? rd_word[DATA_W+5]          : 1'b0;
    assign level    = level_r;

`ifdef RX_FRAME_BUF_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] drop_cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= '0;
        end else if (drop_evt) begin
            drop_cnt_r <= sat_inc(drop_cnt_r);
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    logic drop_evt_unused;
    assign drop_evt_unused = drop_evt;
    assign drop_cnt        = '0;
`endif

endmodule

// File: tb/tb_rx_frame_buf.sv
// Directed testbench for rx_frame_buf (ADDR_WIDTH=4); drop_cnt expectations follow RX_FRAME_BUF_STATS_EN.
module tb_rx_frame_buf;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef RX_FRAME_BUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [63:0]   s_data;
    logic [2:0]    s_nbytes;
    logic          s_sop, s_eop, s_err;
    logic          m_valid, m_ready;
    logic [63:0]   m_data;
    logic [2:0]    m_nbytes;
    logic          m_sop, m_eop, m_err;
    logic [AW:0]   level;
    logic [15:0]   drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [70:0] got, exp;

    always #5 clk = ~clk;

    rx_frame_buf #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_nbytes(s_nbytes),
        .s_sop(s_sop), .s_eop(s_eop), .s_err(s_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_nbytes(m_nbytes),
        .m_sop(m_sop), .m_eop(m_eop), .m_err(m_err),
        .level(level), .drop_cnt(drop_cnt)
    );

    assign got = {m_valid, m_err, m_eop, m_sop, m_nbytes, m_data};

    function automatic logic [70:0] word(bit v, bit err, bit eop, bit sop, logic [2:0] nb, logic [63:0] d);
        return {v, err, eop, sop, nb, d};
    endfunction

    function automatic logic [15:0] exp_drop(int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [63:0] d, logic [2:0] nb, bit sop, bit eop, bit err);
        s_valid = 1'b1; s_data = d; s_nbytes = nb; s_sop = sop; s_eop = eop; s_err = err;
        step();
        s_valid = 1'b0; s_data = '0; s_nbytes = '0; s_sop = 1'b0; s_eop = 1'b0; s_err = 1'b0;
    endtask

    task automatic do_reset();
        m_ready = 1'b0;
        s_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (got !== 71'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", got);
        end
        checks++;
        if (level !== 5'd0) begin
            errors++; $display("FAIL reset_level: got %0d expected 0", level);
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(64'h1111_0000_0000_0000 + 64'(k), (k == 3) ? 3'd5 : 3'd0, k == 0, k == 3, 1'b0);
            exp = word(1'b1, 1'b0, k == 3, k == 0, (k == 3) ? 3'd5 : 3'd0, 64'h1111_0000_0000_0000 + 64'(k));
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL single_w%0d: got %h expected %h", k, got, exp);
            end
        end
        step();
        checks++;
        if (m_valid !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL single_end: got valid=%b level=%0d expected valid=0 level=0", m_valid, level);
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++; $display("FAIL single_drop: got %0d expected 0", drop_cnt);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(64'hA000 + 64'(i), (i == 19) ? 3'd3 : 3'd0, i == 0, i == 19, 1'b0);
            if (i == 15 || i == 19) begin
                checks++;
                if (level !== 5'd16) begin
                    errors++; $display("FAIL ovf_level_%0d: got %0d expected 16", i, level);
                end
            end
        end
        step();
        step();
        checks++;
        if (drop_cnt !== exp_drop(1)) begin
            errors++; $display("FAIL ovf_drop: got %0d expected %0d", drop_cnt, exp_drop(1));
        end
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp = word(1'b1, 1'b0, 1'b0, k == 0, 3'd0, 64'hA000 + 64'(k));
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL ovf_w%0d: got %h expected %h", k, got, exp);
            end
            step();
        end
        exp = word(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 64'd0);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL ovf_term: got %h expected %h", got, exp);
        end
        step();
        checks++;
        if (m_valid !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL ovf_end: got valid=%b level=%0d expected valid=0 level=0", m_valid, level);
        end
        checks++;
        if (drop_cnt !== exp_drop(1)) begin
            errors++; $display("FAIL ovf_drop_end: got %0d expected %0d", drop_cnt, exp_drop(1));
        end
    endtask

    task automatic test_missing_eop();
        do_reset();
        send(64'hA0, 3'd0, 1'b1, 1'b0, 1'b0);
        send(64'hA1, 3'd0, 1'b0, 1'b0, 1'b1);
        send(64'hA2, 3'd0, 1'b0, 1'b0, 1'b0);
        send(64'hB0, 3'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (level !== 5'd3) begin
            errors++; $display("FAIL meop_level_b0: got %0d expected 3", level);
        end
        send(64'hB1, 3'd0, 1'b0, 1'b0, 1'b0);
        send(64'hB2, 3'd2, 1'b0, 1'b1, 1'b0);
        step();
        checks++;
        if (level !== 5'd4) begin
            errors++; $display("FAIL meop_level: got %0d expected 4", level);
        end
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) exp = word(1'b1, k == 1, 1'b0, k == 0, 3'd0, 64'hA0 + 64'(k));
            else       exp = word(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 64'd0);
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL meop_w%0d: got %h expected %h", k, got, exp);
            end
            step();
        end
        checks++;
        if (m_valid !== 1'b0 || drop_cnt !== exp_drop(1)) begin
            errors++; $display("FAIL meop_end: got valid=%b drop=%0d expected valid=0 drop=%0d", m_valid, drop_cnt, exp_drop(1));
        end
    endtask

    task automatic test_stray();
        do_reset();
        send(64'h51, 3'd0, 1'b0, 1'b0, 1'b0);
        send(64'h52, 3'd0, 1'b0, 1'b0, 1'b0);
        send(64'h53, 3'd4, 1'b0, 1'b1, 1'b0);
        step();
        checks++;
        if (m_valid !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL stray_store: got valid=%b level=%0d expected valid=0 level=0", m_valid, level);
        end
        checks++;
        if (drop_cnt !== exp_drop(3)) begin
            errors++; $display("FAIL stray_drop: got %0d expected %0d", drop_cnt, exp_drop(3));
        end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(64'hC000 + 64'(i), 3'(i), 1'b1, 1'b1, 1'b0);
        checks++;
        if (level !== 5'd16) begin
            errors++; $display("FAIL fullrw_fill: got %0d expected 16", level);
        end
        m_ready = 1'b1;
        send(64'hDEAD, 3'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (level !== 5'd15) begin
            errors++; $display("FAIL fullrw_level: got %0d expected 15", level);
        end
        checks++;
        if (drop_cnt !== exp_drop(1)) begin
            errors++; $display("FAIL fullrw_drop: got %0d expected %0d", drop_cnt, exp_drop(1));
        end
        send(64'hDEAE, 3'd0, 1'b0, 1'b0, 1'b0);
        send(64'hDEAF, 3'd1, 1'b0, 1'b1, 1'b0);
        for (int k = 3; k < DEPTH; k++) begin
            exp = word(1'b1, 1'b0, 1'b1, 1'b1, 3'(k), 64'hC000 + 64'(k));
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL fullrw_w%0d: got %h expected %h", k, got, exp);
            end
            step();
        end
        checks++;
        if (m_valid !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL fullrw_empty: got valid=%b level=%0d expected valid=0 level=0", m_valid, level);
        end
        send(64'hE0, 3'd6, 1'b1, 1'b1, 1'b0);
        exp = word(1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 64'hE0);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL fullrw_recover: got %h expected %h", got, exp);
        end
        step();
        checks++;
        if (level !== 5'd0) begin
            errors++; $display("FAIL fullrw_noterm: got %0d expected 0", level);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int i = 0; i < 5; i++) send(64'hF0 + 64'(i), 3'd0, i == 0, 1'b0, 1'b0);
        checks++;
        if (level !== 5'd5) begin
            errors++; $display("FAIL rstmid_fill: got %0d expected 5", level);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (got !== 71'd0 || level !== 5'd0) begin
            errors++; $display("FAIL rstmid_clear: got %h level=%0d expected 0 level=0", got, level);
        end
        send(64'hF9, 3'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (level !== 5'd0 || drop_cnt !== exp_drop(1)) begin
            errors++; $display("FAIL rstmid_nosop: got level=%0d drop=%0d expected level=0 drop=%0d", level, drop_cnt, exp_drop(1));
        end
        send(64'h1234, 3'd7, 1'b1, 1'b1, 1'b1);
        exp = word(1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 64'h1234);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL rstmid_next: got %h expected %h", got, exp);
        end
        m_ready = 1'b1;
        step();
        checks++;
        if (level !== 5'd0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_end: got level=%0d valid=%b expected 0 0", level, m_valid);
        end
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b0;
        s_valid = 1'b0; s_data = '0; s_nbytes = '0; s_sop = 1'b0; s_eop = 1'b0; s_err = 1'b0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_missing_eop();
        test_stray();
        test_full_rw();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
